// File: rtl/dmi_arbiter_pkg.sv
// dmi_arbiter_pkg: DMI request/response types, DTM codes and arbiter FSM states
package dmi_arbiter_pkg;
  localparam int DmiAddrW = 7;
  typedef enum logic [1:0] {DTM_NOP = 2'h0, DTM_READ = 2'h1, DTM_WRITE = 2'h2} dtm_op_e;
  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_FAILED = 2'h2;
  localparam logic [1:0] DTM_BUSY = 2'h3;
  typedef struct packed {
    logic [DmiAddrW-1:0] addr;
    dtm_op_e op;
    logic [31:0] data;
  } dmi_req_t;
  typedef struct packed {
    logic [31:0] data;
    logic [1:0] resp;
  } dmi_resp_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} dmi_arb_state_e;
endpackage

// File: rtl/dmi_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first valid index at or after the pointer
module rr_arbiter #(
  parameter int NumReq = 2,
  parameter int IdxW = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] i_valid,
  input  logic [IdxW-1:0]   i_ptr,
  output logic [NumReq-1:0] o_gnt,
  output logic [IdxW-1:0]   o_idx,
  output logic              o_any
);
  // scan from the farthest offset down so the nearest valid index wins
  always_comb begin
    o_idx = '0;
    for (int i = NumReq - 1; i >= 0; i--)
      o_idx = i_valid[IdxW'((int'(i_ptr) + i) % NumReq)] ? IdxW'((int'(i_ptr) + i) % NumReq) : o_idx;
    o_any = |i_valid;
    o_gnt = '0;
    o_gnt[o_idx] = o_any;
  end
endmodule

// File: rtl/dmi_arbiter.sv
// dmi_arbiter: round-robin share of one DMI channel among NumReq masters; optional DMI_ARB_TIMEOUT_EN
module dmi_arbiter
  import dmi_arbiter_pkg::*;
#(
  parameter int NumReq = 2,
  parameter int TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  dmi_req_t [NumReq-1:0] mst_req_i,
  input  logic [NumReq-1:0]     mst_req_valid_i,
  output logic [NumReq-1:0]     mst_req_ready_o,
  output dmi_resp_t             mst_resp_o,
  output logic [NumReq-1:0]     mst_resp_valid_o,
  input  logic [NumReq-1:0]     mst_resp_ready_i,
  input  logic [NumReq-1:0]     mst_clear_i,
  output dmi_req_t              dmi_req_o,
  output logic                  dmi_req_valid_o,
  input  logic                  dmi_req_ready_i,
  input  dmi_resp_t             dmi_resp_i,
  input  logic                  dmi_resp_valid_i,
  output logic                  dmi_resp_ready_o,
  output logic                  busy_o
);
  localparam int IW = $clog2(NumReq);
  dmi_arb_state_e r_state, w_state_nxt;
  logic [IW-1:0] r_ptr, r_gnt, w_pick_idx, w_ptr_nxt;
  logic [NumReq-1:0] w_pick_oh, w_gnt_oh;
  logic w_pick_any, w_grant, w_clear, w_flush, r_flush, w_timeout, w_drain;
  dmi_req_t r_req;
  dmi_resp_t r_resp;

  rr_arbiter #(.NumReq(NumReq), .IdxW(IW)) u_rr (
    .i_valid(mst_req_valid_i),
    .i_ptr  (r_ptr),
    .o_gnt  (w_pick_oh),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  assign w_grant = (r_state == IDLE) && w_pick_any && !w_drain;
  assign w_gnt_oh = NumReq'(1) << r_gnt;
  assign w_clear = mst_clear_i[r_gnt];
  assign w_flush = r_flush || w_clear;
  assign w_ptr_nxt = (w_pick_idx == IW'(NumReq - 1)) ? '0 : w_pick_idx + 1'b1;
  assign dmi_req_o = r_req;
  assign mst_resp_o = r_resp;
  assign busy_o = (r_state != IDLE);
  assign dmi_resp_ready_o = (r_state == WAIT) || w_drain;

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TimeoutCycles + 1);
  logic [CW-1:0] r_cnt;
  logic r_drain;
  assign w_timeout = (r_state == WAIT) && !dmi_resp_valid_i && (r_cnt == CW'(TimeoutCycles - 1));
  assign w_drain = r_drain;
  // count WAIT cycles; after a timeout swallow the one late downstream response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_drain <= 1'b0;
    end else begin
      r_cnt <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
      r_drain <= w_timeout ? 1'b1 : (r_drain && dmi_resp_valid_i) ? 1'b0 : r_drain;
    end
  end
`else
  assign w_timeout = 1'b0 & (TimeoutCycles > 0);
  assign w_drain = 1'b0;
`endif

  // next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    mst_req_ready_o = '0;
    mst_resp_valid_o = '0;
    dmi_req_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        mst_req_ready_o = w_grant ? w_pick_oh : '0;
        w_state_nxt = w_grant ? REQ : IDLE;
      end
      REQ: begin
        dmi_req_valid_o = 1'b1;
        w_state_nxt = dmi_req_ready_i ? WAIT : REQ;
      end
      WAIT: w_state_nxt = (dmi_resp_valid_i || w_timeout) ? (w_flush ? IDLE : RESP) : WAIT;
      RESP: begin
        mst_resp_valid_o = w_clear ? '0 : w_gnt_oh;
        w_state_nxt = (w_clear || mst_resp_ready_i[r_gnt]) ? IDLE : RESP;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // state, round-robin pointer, captured request/response and flush flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_gnt <= '0;
      r_req <= '0;
      r_resp <= '0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_gnt <= w_pick_idx;
        r_req <= mst_req_i[w_pick_idx];
        r_ptr <= w_ptr_nxt;
        r_flush <= 1'b0;
      end else if ((r_state == REQ || r_state == WAIT) && w_clear) begin
        r_flush <= 1'b1;
      end
      if (r_state == WAIT && dmi_resp_valid_i && !w_flush) r_resp <= dmi_resp_i;
      else if (w_timeout && !w_flush) r_resp <= '{data: '0, resp: DTM_FAILED};
    end
  end
endmodule

// File: tb/tb_dmi_arbiter.sv
// tb_dmi_arbiter: table vectors plus corner sequences, checked against a queue-based scoreboard
module tb_dmi_arbiter;
  import dmi_arbiter_pkg::*;
  localparam int NR = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  dmi_req_t [NR-1:0] mst_req_i;
  logic [NR-1:0] mst_req_valid_i, mst_req_ready_o, mst_resp_valid_o, mst_resp_ready_i, mst_clear_i;
  dmi_resp_t mst_resp_o, dmi_resp_i;
  dmi_req_t dmi_req_o;
  logic dmi_req_valid_o, dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_ready_o, busy_o;

  always #5 clk = ~clk;

  dmi_arbiter #(.NumReq(NR), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .mst_req_i(mst_req_i), .mst_req_valid_i(mst_req_valid_i), .mst_req_ready_o(mst_req_ready_o),
    .mst_resp_o(mst_resp_o), .mst_resp_valid_o(mst_resp_valid_o), .mst_resp_ready_i(mst_resp_ready_i),
    .mst_clear_i(mst_clear_i),
    .dmi_req_o(dmi_req_o), .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_resp_i(dmi_resp_i), .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o),
    .busy_o(busy_o)
  );

  typedef struct packed {
    logic [NR-1:0] oh;
    dmi_resp_t r;
  } er_t;
  typedef struct {
    int m;
    dmi_req_t q;
    logic [1:0] code;
    int lat;
    logic [1:0] ecode;
    logic [31:0] edata;
  } vec_t;

  int n_chk = 0, n_err = 0;
  dmi_req_t mq0[$], mq1[$], exp_dreq[$];
  er_t exp_resp[$];
  int gl[$];
  dmi_req_t ds_req;
  dmi_resp_t last_resp;
  int own, outst, drop, ds_pend, ds_cnt, ds_lat, in_wait, wcnt, timed_out, first_v, acc_cyc, cyc_n, n_resp;
  logic ds_rdy, ds_stray;
  logic [1:0] ds_code;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic mon();
    logic [NR-1:0] eoh;
    er_t e;
    int m;
    if (outst != 0 && mst_clear_i[own] && drop == 0) begin
      drop = 1;
      if (exp_resp.size() > 0) begin
        void'(exp_resp.pop_front());
        outst = 0;
      end
    end
    eoh = (exp_resp.size() > 0) ? exp_resp[0].oh : '0;
    chk("resp_valid", mst_resp_valid_o, eoh);
    if (eoh != 0) begin
      chk("resp_data", mst_resp_o, exp_resp[0].r);
      if ((eoh & mst_resp_ready_i) != 0) begin
        last_resp = mst_resp_o;
        n_resp++;
        void'(exp_resp.pop_front());
        outst = 0;
      end
    end
    chk("dresp_ready", dmi_resp_ready_o, (in_wait != 0) || (timed_out != 0));
    if (dmi_resp_valid_i && dmi_resp_ready_o) begin
      if (ds_pend == 0) chk("stray_ack", 1, 0);
      ds_pend = 0;
      if (timed_out != 0) timed_out = 0;
      else begin
        in_wait = 0;
        if (drop != 0) outst = 0;
        else begin
          e.oh = 2'b01 << own;
          e.r = '{data: ~ds_req.data, resp: ds_code};
          exp_resp.push_back(e);
        end
      end
    end else if (in_wait != 0) begin
      wcnt++;
`ifdef DMI_ARB_TIMEOUT_EN
      if (wcnt == TO) begin
        in_wait = 0;
        timed_out = 1;
        if (drop != 0) outst = 0;
        else begin
          e.oh = 2'b01 << own;
          e.r = '{data: '0, resp: DTM_FAILED};
          exp_resp.push_back(e);
        end
      end
`endif
    end
    if (mst_req_ready_o != 0) begin
      chk("single_grant", $countones(mst_req_ready_o), 1);
      chk("no_outstanding", outst, 0);
      chk("ready_has_valid", |(mst_req_ready_o & ~mst_req_valid_i), 0);
      m = mst_req_ready_o[1] ? 1 : 0;
      if (m == 1 && mq1.size() > 0) exp_dreq.push_back(mq1.pop_front());
      if (m == 0 && mq0.size() > 0) exp_dreq.push_back(mq0.pop_front());
      own = m;
      outst = 1;
      drop = 0;
      gl.push_back(m);
      acc_cyc = cyc_n;
      first_v = 1;
    end
    if (dmi_req_valid_o) begin
      if (exp_dreq.size() == 0) chk("spurious_dreq", 1, 0);
      else begin
        chk("dreq", dmi_req_o, exp_dreq[0]);
        if (first_v != 0) begin
          chk("req_latency", cyc_n - acc_cyc, 1);
          first_v = 0;
        end
        if (dmi_req_ready_i) begin
          ds_req = exp_dreq.pop_front();
          ds_pend = 1;
          ds_cnt = ds_lat;
          in_wait = 1;
          wcnt = 0;
        end
      end
    end
  endtask

  task automatic cyc();
    mst_req_valid_i = {mq1.size() > 0, mq0.size() > 0};
    mst_req_i[0] = (mq0.size() > 0) ? mq0[0] : '0;
    mst_req_i[1] = (mq1.size() > 0) ? mq1[0] : '0;
    dmi_req_ready_i = ds_rdy;
    dmi_resp_valid_i = (ds_pend != 0 && ds_cnt == 0) || ds_stray;
    dmi_resp_i = '{data: ~ds_req.data, resp: ds_code};
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    cyc_n++;
    if (ds_pend != 0 && ds_cnt > 0) ds_cnt--;
  endtask

  task automatic run(input int maxc);
    int c = 0;
    while ((mq0.size() > 0 || mq1.size() > 0 || outst != 0 || ds_pend != 0 || timed_out != 0) && c < maxc) begin
      cyc();
      c++;
    end
    chk("run_bound", c < maxc, 1);
    cyc();
  endtask

  task automatic wait_for(input int what, input int maxc);
    int c = 0;
    while (c < maxc && !(what == 0 ? in_wait != 0 : what == 1 ? exp_resp.size() > 0 : dmi_req_valid_o == 1'b1)) begin
      cyc();
      c++;
    end
    chk("wait_bound", c < maxc, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tv[4];
    int n0;
    tv[0] = '{0, {7'h10, DTM_WRITE, 32'hDEADBEEF}, DTM_SUCCESS, 0, DTM_SUCCESS, 32'h21524110};
    tv[1] = '{1, {7'h11, DTM_READ, 32'h0000_0000}, DTM_SUCCESS, 2, DTM_SUCCESS, 32'hFFFFFFFF};
    tv[2] = '{0, {7'h7F, DTM_WRITE, 32'hFFFFFFFF}, DTM_BUSY, 1, DTM_BUSY, 32'h0000_0000};
    tv[3] = '{1, {7'h00, DTM_NOP, 32'h12345678}, DTM_FAILED, 0, DTM_FAILED, 32'hEDCBA987};
    own = 0; outst = 0; drop = 0; ds_pend = 0; ds_cnt = 0; ds_lat = 0; in_wait = 0; wcnt = 0;
    timed_out = 0; first_v = 0; acc_cyc = 0; cyc_n = 0; n_resp = 0;
    ds_rdy = 1'b1; ds_stray = 1'b0; ds_code = DTM_SUCCESS; ds_req = '0; last_resp = '0;
    rst = 1'b1;
    mst_req_i = '0; mst_req_valid_i = '0; mst_resp_ready_i = '1; mst_clear_i = '0;
    dmi_req_ready_i = 1'b0; dmi_resp_i = '0; dmi_resp_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", mst_req_ready_o, 0);
    chk("rst_resp_valid", mst_resp_valid_o, 0);
    chk("rst_dreq_valid", dmi_req_valid_o, 0);
    chk("rst_dresp_ready", dmi_resp_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_dreq", dmi_req_o, 0);
    chk("rst_mresp", mst_resp_o, 0);
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 4; i++) begin
      ds_code = tv[i].code;
      ds_lat = tv[i].lat;
      n0 = n_resp;
      if (tv[i].m == 0) mq0.push_back(tv[i].q);
      else mq1.push_back(tv[i].q);
      run(50);
      chk("vec_count", n_resp - n0, 1);
      chk("vec_code", last_resp.resp, tv[i].ecode);
      chk("vec_data", last_resp.data, tv[i].edata);
    end

    ds_code = DTM_SUCCESS;
    ds_lat = 0;
    gl.delete();
    for (int i = 0; i < 4; i++) begin
      mq0.push_back({7'h20, DTM_WRITE, 32'h100 + i});
      mq1.push_back({7'h30, DTM_READ, 32'h200 + i});
    end
    run(200);
    chk("rr_count", gl.size(), 8);
    for (int i = 0; i < 8 && i < gl.size(); i++) chk("rr_order", gl[i], i % 2);

    ds_rdy = 1'b0;
    mq0.push_back({7'h44, DTM_WRITE, 32'hCAFEF00D});
    wait_for(2, 10);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("req_held", dmi_req_valid_o, 1);
    end
    ds_rdy = 1'b1;
    run(50);

    ds_lat = 4;
    n0 = n_resp;
    mq0.push_back({7'h50, DTM_READ, 32'h0BAD0BAD});
    wait_for(0, 20);
    mq1.push_back({7'h51, DTM_READ, 32'h600DF00D});
    mst_clear_i = 2'b01;
    cyc();
    mst_clear_i = 2'b00;
    run(80);
    chk("clear_wait_resps", n_resp - n0, 1);
    chk("clear_next_gnt", gl[gl.size() - 1], 1);

    n0 = n_resp;
    mq1.push_back({7'h52, DTM_WRITE, 32'h13579BDF});
    wait_for(0, 20);
    mst_clear_i = 2'b01;
    cyc();
    mst_clear_i = 2'b00;
    run(80);
    chk("clear_other_resps", n_resp - n0, 1);

    ds_lat = 0;
    mst_resp_ready_i = 2'b01;
    mq1.push_back({7'h60, DTM_READ, 32'h2468ACE0});
    wait_for(1, 20);
    mq0.push_back({7'h61, DTM_WRITE, 32'h11112222});
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("resp_hold", mst_resp_valid_o, 2'b10);
      chk("resp_block", mst_req_ready_o, 0);
    end
    mst_resp_ready_i = 2'b11;
    run(80);

    mst_resp_ready_i = 2'b10;
    n0 = n_resp;
    mq0.push_back({7'h62, DTM_READ, 32'h33334444});
    wait_for(1, 20);
    mst_clear_i = 2'b01;
    cyc();
    mst_clear_i = 2'b00;
    chk("clear_resp_idle", busy_o, 0);
    mst_resp_ready_i = 2'b11;
    cyc();
    chk("clear_resp_count", n_resp - n0, 0);

    ds_lat = 20;
    ds_code = DTM_SUCCESS;
    mq0.push_back({7'h70, DTM_READ, 32'h55AA55AA});
    run(100);
`ifdef DMI_ARB_TIMEOUT_EN
    chk("timeout_code", last_resp.resp, DTM_FAILED);
    chk("timeout_data", last_resp.data, 0);
`else
    chk("slow_code", last_resp.resp, DTM_SUCCESS);
    chk("slow_data", last_resp.data, 32'hAA55AA55);
`endif

    ds_stray = 1'b1;
    repeat (2) cyc();
    ds_stray = 1'b0;

    mq0.push_back({7'h71, DTM_WRITE, 32'h77778888});
    wait_for(0, 20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq0.delete(); mq1.delete(); exp_dreq.delete(); exp_resp.delete();
    outst = 0; ds_pend = 0; in_wait = 0; timed_out = 0; first_v = 0; drop = 0;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_dresp_ready", dmi_resp_ready_o, 0);
    ds_stray = 1'b1;
    repeat (3) cyc();
    ds_stray = 1'b0;
    ds_lat = 0;
    gl.delete();
    mq0.push_back({7'h72, DTM_READ, 32'h9});
    mq1.push_back({7'h73, DTM_READ, 32'hA});
    run(50);
    chk("midrst_count", gl.size(), 2);
    if (gl.size() == 2) begin
      chk("midrst_first", gl[0], 0);
      chk("midrst_second", gl[1], 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
